fp_compare_pipe: RTL and testbench

// Pipelined, multi-lane FloPoCo-format floating-point comparator for the Ray-AABB

---
 rtl/fp_compare_pipe.sv | 178 +++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// Two-stage, multi-lane comparator for FloPoCo-encoded floats {exc,sign,exp,frac}.
// S1 holds the per-lane ordering (gt/eq, NaN), S2 holds the op-decoded flag/res/unordered.
module fp_compare_pipe #(
    parameter int WE    = 5,
    parameter int WF    = 7,
    parameter int LANES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     op,
    input  logic [LANES*(WE+WF+3)-1:0]     inA,
    input  logic [LANES*(WE+WF+3)-1:0]     inB,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES-1:0]               flag,
    output logic [LANES*(WE+WF+3)-1:0]     res,
    output logic [LANES-1:0]               unordered
);

    localparam int W  = WE + WF + 3;
    localparam int KW = WE + WF + 2;

    localparam logic [2:0] OP_LT  = 3'b000;
    localparam logic [2:0] OP_LE  = 3'b001;
    localparam logic [2:0] OP_GT  = 3'b011;
    localparam logic [2:0] OP_GE  = 3'b100;
    localparam logic [2:0] OP_MIN = 3'b101;
    localparam logic [2:0] OP_MAX = 3'b110;

    // Zero of either sign maps to key 0 so +0 and -0 land on the same point.
    function automatic logic [KW-1:0] order_key(input logic [W-1:0] x);
        if (x[W-1:W-2] == 2'b00) begin
            return '0;
        end
        return {x[W-1:W-2], x[W-4:0]};
    endfunction

    function automatic logic [1:0] cmp_gt_eq(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [KW-1:0] ka;
        logic [KW-1:0] kb;
        logic          neg_a;
        logic          neg_b;
        logic          gt;
        logic          eq;
        ka    = order_key(a);
        kb    = order_key(b);
        neg_a = a[W-3] && (ka != '0);
        neg_b = b[W-3] && (kb != '0);
        eq    = (neg_a == neg_b) && (ka == kb);
        if (neg_a != neg_b) begin
            gt = neg_b;
        end else if (neg_a) begin
            gt = ka < kb;
        end else begin
            gt = ka > kb;
        end
        return {gt, eq};
    endfunction

    logic                 en;

    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic [LANES*W-1:0]   s1_a_q, s1_a_d;
    logic [LANES*W-1:0]   s1_b_q, s1_b_d;
    logic [LANES-1:0]     s1_nan_a_q, s1_nan_a_d;
    logic [LANES-1:0]     s1_nan_b_q, s1_nan_b_d;
    logic [LANES-1:0]     s1_gt_q, s1_gt_d;
    logic [LANES-1:0]     s1_eq_q, s1_eq_d;

    logic                 out_valid_q, out_valid_d;
    logic [LANES-1:0]     flag_q, flag_d;
    logic [LANES*W-1:0]   res_q, res_d;
    logic [LANES-1:0]     unord_q, unord_d;

    logic [LANES-1:0]     flag_c;
    logic [LANES*W-1:0]   res_c;
    logic [LANES-1:0]     unord_c;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_nan_a_d = s1_nan_a_q;
        s1_nan_b_d = s1_nan_b_q;
        s1_gt_d    = s1_gt_q;
        s1_eq_d    = s1_eq_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_op_d    = op;
            s1_a_d     = inA;
            s1_b_d     = inB;
            for (int i = 0; i < LANES; i++) begin
                s1_nan_a_d[i] = (inA[i*W+W-1 -: 2] == 2'b11);
                s1_nan_b_d[i] = (inB[i*W+W-1 -: 2] == 2'b11);
                {s1_gt_d[i], s1_eq_d[i]} = cmp_gt_eq(inA[i*W +: W], inB[i*W +: W]);
            end
        end
    end

    // MIN/MAX prefer the non-NaN operand and keep A on ties or when both are NaN.
    always_comb begin
        flag_c  = '0;
        res_c   = s1_a_q;
        unord_c = s1_nan_a_q | s1_nan_b_q;
        for (int i = 0; i < LANES; i++) begin
            case (s1_op_q)
                OP_LT:   flag_c[i] = !unord_c[i] && !s1_gt_q[i] && !s1_eq_q[i];
                OP_LE:   flag_c[i] = !unord_c[i] && !s1_gt_q[i];
                OP_GT:   flag_c[i] = !unord_c[i] && s1_gt_q[i];
                OP_GE:   flag_c[i] = !unord_c[i] && (s1_gt_q[i] || s1_eq_q[i]);
                OP_MIN:  flag_c[i] = s1_nan_a_q[i] ? !s1_nan_b_q[i]
                                                   : (!s1_nan_b_q[i] && s1_gt_q[i]);
                OP_MAX:  flag_c[i] = s1_nan_a_q[i] ? !s1_nan_b_q[i]
                                                   : (!s1_nan_b_q[i] && !s1_gt_q[i] && !s1_eq_q[i]);
                default: flag_c[i] = !unord_c[i] && s1_eq_q[i];
            endcase
            if ((s1_op_q == OP_MIN || s1_op_q == OP_MAX) && flag_c[i]) begin
                res_c[i*W +: W] = s1_b_q[i*W +: W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        flag_d      = flag_q;
        res_d       = res_q;
        unord_d     = unord_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            flag_d      = flag_c;
            res_d       = res_c;
            unord_d     = unord_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_nan_a_q  <= '0;
            s1_nan_b_q  <= '0;
            s1_gt_q     <= '0;
            s1_eq_q     <= '0;
            out_valid_q <= 1'b0;
            flag_q      <= '0;
            res_q       <= '0;
            unord_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_nan_a_q  <= s1_nan_a_d;
            s1_nan_b_q  <= s1_nan_b_d;
            s1_gt_q     <= s1_gt_d;
            s1_eq_q     <= s1_eq_d;
            out_valid_q <= out_valid_d;
            flag_q      <= flag_d;
            res_q       <= res_d;
            unord_q     <= unord_d;
        end
    end

    assign out_valid = out_valid_q;
    assign flag      = flag_q;
    assign res       = res_q;
    assign unordered = unord_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe with 4 lanes: hand-computed directed beats, reset flush,
// back-to-back random beats against a signed-key model, and random output backpressure.
module tb_fp_compare_pipe;

    localparam int WE    = 5;
    localparam int WF    = 7;
    localparam int LANES = 4;
    localparam int W     = WE + WF + 3;

    localparam logic [14:0] ONE  = 15'h2780;
    localparam logic [14:0] TWO  = 15'h2800;
    localparam logic [14:0] NONE = 15'h3780;
    localparam logic [14:0] PZ   = 15'h0000;
    localparam logic [14:0] NZ   = 15'h1000;
    localparam logic [14:0] PINF = 15'h4000;
    localparam logic [14:0] NINF = 15'h5000;
    localparam logic [14:0] QNAN = 15'h6000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [2:0]           op = 3'b000;
    logic [LANES*W-1:0]   inA = '0;
    logic [LANES*W-1:0]   inB = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [LANES-1:0]     flag;
    logic [LANES*W-1:0]   res;
    logic [LANES-1:0]     unordered;

    fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag      (flag),
        .res       (res),
        .unordered (unordered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0]   flag;
        logic [LANES*W-1:0] res;
        logic [LANES-1:0]   unord;
        int                 cyc;
        bit                 lat;
    } exp_t;

    exp_t               expQ[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    bit                 checkLat = 1'b0;
    bit                 bpMode = 1'b0;
    logic [LANES-1:0]   pendFlag = '0;
    logic [LANES*W-1:0] pendRes = '0;
    logic [LANES-1:0]   pendUnord = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sval(input logic [14:0] x);
        int k;
        k = (x[14:13] == 2'b00) ? 0 : int'({x[14:13], x[11:0]});
        return (x[12] && k != 0) ? -k : k;
    endfunction

    task automatic model(input logic [2:0] mop, input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                         output logic [LANES-1:0] f, output logic [LANES*W-1:0] r,
                         output logic [LANES-1:0] u);
        f = '0;
        r = a;
        u = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [14:0] la, lb;
            logic        na, nb, selB;
            int          sa, sb;
            la = a[i*W +: W];
            lb = b[i*W +: W];
            na = (la[14:13] == 2'b11);
            nb = (lb[14:13] == 2'b11);
            sa = sval(la);
            sb = sval(lb);
            u[i] = na | nb;
            selB = 1'b0;
            case (mop)
                3'd0: f[i] = !u[i] && (sa <  sb);
                3'd1: f[i] = !u[i] && (sa <= sb);
                3'd3: f[i] = !u[i] && (sa >  sb);
                3'd4: f[i] = !u[i] && (sa >= sb);
                3'd5, 3'd6: begin
                    if (na && nb)  selB = 1'b0;
                    else if (na)   selB = 1'b1;
                    else if (nb)   selB = 1'b0;
                    else           selB = (mop == 3'd5) ? (sb < sa) : (sb > sa);
                    f[i] = selB;
                    if (selB) r[i*W +: W] = lb;
                end
                default: f[i] = !u[i] && (sa == sb);
            endcase
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle, so a handshake seen here completes on the next rising edge.
    bit                 stallPrev = 1'b0;
    logic [LANES-1:0]   heldFlag;
    logic [LANES*W-1:0] heldRes;
    logic [LANES-1:0]   heldUnord;

    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_flag", 64'(flag), 64'(heldFlag));
                checkOutput("hold_res", 64'(res), 64'(heldRes));
                checkOutput("hold_unord", 64'(unordered), 64'(heldUnord));
            end
            stallPrev = out_valid && !out_ready;
            heldFlag  = flag;
            heldRes   = res;
            heldUnord = unordered;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("flag", 64'(flag), 64'(e.flag));
                    checkOutput("res", 64'(res), 64'(e.res));
                    checkOutput("unordered", 64'(unordered), 64'(e.unord));
                    if (e.lat && checkLat) checkOutput("latency", 64'(cyc), 64'(e.cyc + 2));
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.flag  = pendFlag;
                n.res   = pendRes;
                n.unord = pendUnord;
                n.cyc   = cyc;
                n.lat   = checkLat;
                expQ.push_back(n);
            end
        end
    end

    // Output backpressure: random high runs and low runs of 1, 2 or 5 cycles, first low run is 5.
    initial begin
        int  run;
        bit  first;
        run   = 0;
        first = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bpMode) begin
                out_ready = 1'b1;
            end else begin
                if (run <= 0) begin
                    if (out_ready) begin
                        out_ready = 1'b0;
                        if (first) run = 5;
                        else case ($urandom_range(0, 2))
                            0:       run = 1;
                            1:       run = 2;
                            default: run = 5;
                        endcase
                        first = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                        run = $urandom_range(1, 3);
                    end
                end
                run--;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic applyStimulus(input logic [2:0] sop, input logic [LANES*W-1:0] a,
                                 input logic [LANES*W-1:0] b, input logic [LANES-1:0] ef,
                                 input logic [LANES*W-1:0] er, input logic [LANES-1:0] eu);
        int guard;
        in_valid  = 1'b1;
        op        = sop;
        inA       = a;
        inB       = b;
        pendFlag  = ef;
        pendRes   = er;
        pendUnord = eu;
        guard     = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [14:0] randVal();
        logic [14:0] pool [8];
        pool[0] = ONE;  pool[1] = TWO;  pool[2] = NONE; pool[3] = PZ;
        pool[4] = NZ;   pool[5] = PINF; pool[6] = NINF; pool[7] = QNAN;
        if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 7)];
        return 15'($urandom_range(0, 32767));
    endfunction

    task automatic sendRandom();
        logic [LANES*W-1:0] a, b, r;
        logic [LANES-1:0]   f, u;
        logic [2:0]         rop;
        for (int i = 0; i < LANES; i++) begin
            a[i*W +: W] = randVal();
            b[i*W +: W] = ($urandom_range(0, 4) == 0) ? a[i*W +: W] : randVal();
        end
        rop = 3'($urandom_range(0, 7));
        model(rop, a, b, f, r, u);
        applyStimulus(rop, a, b, f, r, u);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_res", 64'(res), 64'd0);
        checkOutput("rst_flag", 64'(flag), 64'd0);
        checkOutput("rst_unord", 64'(unordered), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed beats, lanes packed {l3,l2,l1,l0}; expectations worked by hand.
        checkLat = 1'b1;
        applyStimulus(3'b000, {PZ, TWO, NONE, ONE}, {NZ, ONE, PZ, TWO},
                      4'b0011, {PZ, TWO, NONE, ONE}, 4'b0000);
        applyStimulus(3'b011, {NZ, PINF, TWO, NONE}, {PZ, TWO, ONE, ONE},
                      4'b0110, {NZ, PINF, TWO, NONE}, 4'b0000);
        applyStimulus(3'b010, {QNAN, ONE, ONE, PZ}, {QNAN, NONE, ONE, NZ},
                      4'b0011, {QNAN, ONE, ONE, PZ}, 4'b1000);
        applyStimulus(3'b101, {QNAN, NONE, TWO, PZ}, {TWO, ONE, ONE, NZ},
                      4'b1010, {TWO, NONE, ONE, PZ}, 4'b1000);
        applyStimulus(3'b100, {NONE, NINF, ONE, PINF}, {NINF, NONE, ONE, TWO},
                      4'b1011, {NONE, NINF, ONE, PINF}, 4'b0000);
        applyStimulus(3'b001, {TWO, TWO, ONE, QNAN}, {ONE, TWO, TWO, ONE},
                      4'b0110, {TWO, TWO, ONE, QNAN}, 4'b0001);
        applyStimulus(3'b110, {NZ, ONE, QNAN, QNAN}, {PZ, TWO, QNAN, ONE},
                      4'b0101, {NZ, TWO, QNAN, ONE}, 4'b0011);
        applyStimulus(3'b111, {PINF, NZ, ONE, ONE}, {PINF, PZ, TWO, ONE},
                      4'b1101, {PINF, NZ, ONE, ONE}, 4'b0000);
        waitDrain();

        // Reset with beats still in flight: nothing from before the reset may come out.
        repeat (3) sendRandom();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_res", 64'(res), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] streaming 20 back-to-back beats");
        repeat (20) sendRandom();
        waitDrain();

        $display("[TB] streaming 40 beats under output backpressure");
        checkLat = 1'b0;
        bpMode   = 1'b1;
        repeat (40) sendRandom();
        waitDrain();
        bpMode = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=%0d expected=done", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
